divide_128x64: RTL and testbench

DIVIDE_128X64 -- requirements
Module: divide_128x64

---
 rtl/divide_128x64.sv | 104 ++++++++++
 tb/tb_divide_128x64.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_128x64.sv
// divide_128x64: unsigned 2*BITS / BITS restoring divider, radix-2 by default, radix-4 with DIVIDE_RADIX4_EN.
// Overflowing requests (high dividend half >= divisor, including divide by zero) finish in a single cycle.
module divide_128x64 #(
    parameter int BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*BITS-1:0] dividend,
    input  logic [BITS-1:0]   divisor,
    output logic              busy,
    output logic              done,
    output logic [BITS-1:0]   quotient,
    output logic [BITS-1:0]   remainder,
    output logic              overflow,
    output logic              div_by_zero
);
`ifdef DIVIDE_RADIX4_EN
    localparam int STEPS = BITS / 2;
`else
    localparam int STEPS = BITS;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [2*BITS-1:0] r_acc;
    logic [BITS-1:0]   r_div;
    logic [CW-1:0]     r_cnt;
    logic [2*BITS-1:0] w_next;
    logic              w_ovf;

    // r_acc holds {partial remainder, remaining dividend bits / quotient bits shifted in at the bottom}
    function automatic logic [2*BITS-1:0] f_step(input logic [2*BITS-1:0] acc, input logic [BITS-1:0] d);
        logic [BITS:0] w;
        logic          ge;
        w  = acc[2*BITS-1:BITS-1];
        ge = w >= {1'b0, d};
        return {ge ? w[BITS-1:0] - d : w[BITS-1:0], acc[BITS-2:0], ge};
    endfunction

    always_comb begin
`ifdef DIVIDE_RADIX4_EN
        w_next = f_step(f_step(r_acc, r_div), r_div);
`else
        w_next = f_step(r_acc, r_div);
`endif
        w_ovf = dividend[2*BITS-1:BITS] >= divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= w_next[BITS-1:0];
                        remainder <= w_next[2*BITS-1:BITS];
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        if (w_ovf) begin
                            r_state     <= DONE;
                            done        <= 1'b1;
                            quotient    <= '0;
                            remainder   <= '0;
                            overflow    <= 1'b1;
                            div_by_zero <= divisor == '0;
                        end else begin
                            r_state     <= RUN;
                            busy        <= 1'b1;
                            r_acc       <= dividend;
                            r_div       <= divisor;
                            r_cnt       <= '0;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divide_128x64.sv
// tb_divide_128x64: directed-vector bench for divide_128x64; cycle 0 is the cycle start is high.
module tb_divide_128x64;
    localparam int BITS = 64;
`ifdef DIVIDE_RADIX4_EN
    localparam int LAT = BITS / 2 + 1;
`else
    localparam int LAT = BITS + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic         busy;
    logic         done;
    logic [63:0]  quotient;
    logic [63:0]  remainder;
    logic         overflow;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    divide_128x64 #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Called #1 after a rising edge; returns in the done cycle (or after the cycle budget).
    task automatic run_op(input logic [127:0] dd, input logic [63:0] dv, output int lat, output logic busy_ok);
        start = 1'b1;
        dividend = dd;
        divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b, want all 0",
                     busy, done, quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic ok;
        run_op(128'd100, 64'd7, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy profile wrong, got %b want 1", ok); end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {64'd14, 64'd2, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result: got q=%0d r=%0d ovf=%b dbz=%b want q=14 r=2 ovf=0 dbz=0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic ok;
        run_op({64'd123, 64'd456}, 64'd0, lat, ok);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL dz_busy: busy seen high, got %b want 1", ok); end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {64'd0, 64'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL dz_result: got q=%h r=%h ovf=%b dbz=%b want 0 0 1 1",
                     quotient, remainder, overflow, div_by_zero);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, overflow, div_by_zero, quotient, remainder} !== {1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 64'd0}) begin
            n_bad++;
            $display("FAIL dz_hold: got done=%b busy=%b ovf=%b dbz=%b q=%h r=%h want done=0 busy=0 ovf=1 dbz=1 q=0 r=0",
                     done, busy, overflow, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_wide();
        int lat;
        logic ok;
        run_op({64'd5, 64'd3}, 64'd6, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL wide_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {64'd15372286728091293013, 64'd5, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL wide_result: got q=%0d r=%0d ovf=%b dbz=%b want q=15372286728091293013 r=5 ovf=0 dbz=0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic ok;
        run_op({64'd7, 64'd0}, 64'd7, lat, ok);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL ovf_latency: got %0d want 1", lat); end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {64'd0, 64'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ovf_result: got q=%h r=%h ovf=%b dbz=%b want 0 0 1 0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        logic ok;
        // Largest non-overflowing case: (2^64-1)*2^64 - 1 + ... gives q=2^64-1, r=2^64-2
        run_op({64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
            n_bad++;
            $display("FAIL max_result: got q=%h r=%h ovf=%b want q=ffffffffffffffff r=fffffffffffffffe ovf=0",
                     quotient, remainder, overflow);
        end
        run_op(128'd5, 64'd9, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL small_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'd0, 64'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL small_result: got q=%0d r=%0d ovf=%b want q=0 r=5 ovf=0", quotient, remainder, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic ok;
        start = 1'b1;
        dividend = 128'd100;
        divisor = 64'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = {64'd1, 64'd0};
        divisor = 64'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        lat = 11;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'd14, 64'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_first_result: got q=%0d r=%0d ovf=%b want q=14 r=2 ovf=0", quotient, remainder, overflow);
        end
        run_op({64'd5, 64'd3}, 64'd6, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'd15372286728091293013, 64'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second_result: got q=%0d r=%0d ovf=%b want q=15372286728091293013 r=5 ovf=0",
                     quotient, remainder, overflow);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic ok;
        logic seen;
        start = 1'b1;
        dividend = {64'd5, 64'd3};
        divisor = 64'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b want all 0",
                     busy, done, quotient, remainder, overflow, div_by_zero);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midrun_no_done: got activity=%b want 0", seen); end
        run_op(128'd100, 64'd7, lat, ok);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL midrun_fresh_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {64'd14, 64'd2, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midrun_fresh_result: got q=%0d r=%0d ovf=%b dbz=%b want q=14 r=2 ovf=0 dbz=0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_rst_priority();
        logic seen;
        rst = 1'b1;
        start = 1'b1;
        dividend = 128'd100;
        divisor = 64'd7;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder} !== '0) begin
            n_bad++;
            $display("FAIL prio_outputs: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
        end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL prio_no_done: got activity=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_wide();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_reset_midrun();
        test_rst_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
